// File: rtl/ps2_kb_pkg.sv
// Shared definitions for the PS/2 keyboard decoder: FSM states, scan-code
// constants (set 2) and the ASCII control characters the decoder can emit.
package ps2_kb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } kb_state_e;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_ENTER  = 8'h5A;

   // Keyboard-to-host status bytes; they share no map entry but are never keys.
   localparam logic [7:0] SC_ACK    = 8'hFA;
   localparam logic [7:0] SC_BAT_OK = 8'hAA;
   localparam logic [7:0] SC_ECHO   = 8'hEE;
   localparam logic [7:0] SC_RESEND = 8'hFE;

   localparam logic [7:0] ASCII_NUL   = 8'h00;
   localparam logic [7:0] ASCII_BS    = 8'h08;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_ESC   = 8'h1B;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

   function automatic logic is_status_code(input logic [7:0] code);
      return (code == SC_ACK) || (code == SC_BAT_OK) ||
             (code == SC_ECHO) || (code == SC_RESEND);
   endfunction

   function automatic logic is_lower_letter(input logic [7:0] ch);
      return (ch >= 8'h61) && (ch <= 8'h7A);
   endfunction

endpackage

// File: rtl/ps2_key_decoder_key_fifo.sv
// First-word-fall-through key FIFO; an extra pointer bit separates full from
// empty, and a push into a full FIFO is accepted only alongside a pop.
module key_fifo #(
   parameter int FIFO_AW = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full
);

   localparam int DEPTH = 1 << FIFO_AW;

   logic [7:0]       mem_q [DEPTH];
   logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
   logic             do_push;
   logic             do_pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                  (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries no reset; the head is only meaningful while not empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[FIFO_AW-1:0]] <= din;
      end
   end

   assign dout = mem_q[rd_ptr_q[FIFO_AW-1:0]];

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 set-2 scan bytes into ASCII key presses, tracking shift and
// caps-lock state, and queues the characters in a small FIFO.
module ps2_key_decoder
   import ps2_kb_pkg::*;
#(
   parameter int FIFO_AW = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_done_tick,
   input  logic [7:0] dout,
   input  logic       rd_key,
   output logic [7:0] key_ascii,
   output logic       key_empty,
   output logic       key_overflow,
   output logic       caps_led
);

   kb_state_e  state_q, state_d;
   logic       shift_l_q, shift_l_d;
   logic       shift_r_q, shift_r_d;
   logic       caps_q, caps_d;
   logic       overflow_q, overflow_d;

   logic [7:0] map_ascii;
   logic       map_is_letter;
   logic       upper;
   logic [7:0] key_char;
   logic       push;
   logic [7:0] push_data;
   logic [7:0] fifo_dout;
   logic       fifo_empty;
   logic       fifo_full;

   always_comb begin
      map_ascii = ASCII_NUL;
      case (dout)
         8'h1C: map_ascii = "a";
         8'h32: map_ascii = "b";
         8'h21: map_ascii = "c";
         8'h23: map_ascii = "d";
         8'h24: map_ascii = "e";
         8'h2B: map_ascii = "f";
         8'h34: map_ascii = "g";
         8'h33: map_ascii = "h";
         8'h43: map_ascii = "i";
         8'h3B: map_ascii = "j";
         8'h42: map_ascii = "k";
         8'h4B: map_ascii = "l";
         8'h3A: map_ascii = "m";
         8'h31: map_ascii = "n";
         8'h44: map_ascii = "o";
         8'h4D: map_ascii = "p";
         8'h15: map_ascii = "q";
         8'h2D: map_ascii = "r";
         8'h1B: map_ascii = "s";
         8'h2C: map_ascii = "t";
         8'h3C: map_ascii = "u";
         8'h2A: map_ascii = "v";
         8'h1D: map_ascii = "w";
         8'h22: map_ascii = "x";
         8'h35: map_ascii = "y";
         8'h1A: map_ascii = "z";
         8'h45: map_ascii = "0";
         8'h16: map_ascii = "1";
         8'h1E: map_ascii = "2";
         8'h26: map_ascii = "3";
         8'h25: map_ascii = "4";
         8'h2E: map_ascii = "5";
         8'h36: map_ascii = "6";
         8'h3D: map_ascii = "7";
         8'h3E: map_ascii = "8";
         8'h46: map_ascii = "9";
         8'h29: map_ascii = ASCII_SPACE;
         8'h5A: map_ascii = ASCII_CR;
         8'h66: map_ascii = ASCII_BS;
         8'h76: map_ascii = ASCII_ESC;
         default: map_ascii = ASCII_NUL;
      endcase
   end

   // Caps lock inverts the shift sense, but only for letters.
   assign map_is_letter = is_lower_letter(map_ascii);
   assign upper         = map_is_letter & ((shift_l_q | shift_r_q) ^ caps_q);
   assign key_char      = upper ? (map_ascii & ~ASCII_CASE_BIT) : map_ascii;

   always_comb begin
      state_d   = state_q;
      shift_l_d = shift_l_q;
      shift_r_d = shift_r_q;
      caps_d    = caps_q;
      push      = 1'b0;
      push_data = key_char;
      if (rx_done_tick) begin
         case (state_q)
            ST_IDLE: begin
               if (dout == SC_EXT) begin
                  state_d = ST_EXT;
               end else if (dout == SC_BRK) begin
                  state_d = ST_BRK;
               end else if (dout == SC_LSHIFT) begin
                  shift_l_d = 1'b1;
               end else if (dout == SC_RSHIFT) begin
                  shift_r_d = 1'b1;
               end else if (dout == SC_CAPS) begin
                  caps_d = ~caps_q;
               end else if ((map_ascii != ASCII_NUL) && !is_status_code(dout)) begin
                  push = 1'b1;
               end
            end
            ST_EXT: begin
               if (dout == SC_BRK) begin
                  state_d = ST_EXT_BRK;
               end else begin
                  state_d = ST_IDLE;
                  // Keypad Enter is the only extended key we translate.
                  if (dout == SC_ENTER) begin
                     push      = 1'b1;
                     push_data = ASCII_CR;
                  end
               end
            end
            ST_BRK: begin
               state_d = ST_IDLE;
               if (dout == SC_LSHIFT) shift_l_d = 1'b0;
               if (dout == SC_RSHIFT) shift_r_d = 1'b0;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign overflow_d = overflow_q | (push & fifo_full & ~rd_key);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         shift_l_q  <= 1'b0;
         shift_r_q  <= 1'b0;
         caps_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_l_q  <= shift_l_d;
         shift_r_q  <= shift_r_d;
         caps_q     <= caps_d;
         overflow_q <= overflow_d;
      end
   end

   key_fifo #(
      .FIFO_AW (FIFO_AW)
   ) u_key_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (push_data),
      .pop   (rd_key),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign key_ascii    = fifo_empty ? ASCII_NUL : fifo_dout;
   assign key_empty    = fifo_empty;
   assign key_overflow = overflow_q;
   assign caps_led     = caps_q;

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter FIFO_AW, default 2, meaning key FIFO address width (depth = 2**FIFO_AW entries).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx_done_tick  input  1  one-cycle strobe from the PS/2 receiver; the scan byte is valid this cycle.
REQ-005 SHALL have port dout  input  8  received scan-code byte (set 2).
REQ-006 SHALL have port rd_key  input  1  pop request for the FIFO head.
REQ-007 SHALL have port key_ascii  output  8  FIFO head ASCII code; first-word fall-through.
REQ-008 SHALL have port key_empty  output  1  FIFO empty.
REQ-009 SHALL have port key_overflow  output  1  sticky flag: a key was dropped because the FIFO was full.
REQ-010 SHALL have port caps_led  output  1  current Caps Lock state.

Function
REQ-011 SHALL consume a byte only in cycles with rx_done_tick=1, sampling dout in that same cycle.
REQ-012 SHALL run an FSM with states IDLE, EXT (after E0), BRK (after F0) and EXT_BRK (after E0 F0).
REQ-013 SHALL apply these IDLE transitions: E0 -> EXT; F0 -> BRK; any other byte is a make code and the state stays IDLE.
REQ-014 SHALL, in IDLE, set shift_l on make 12, set shift_r on make 59, and toggle caps on make 58, pushing nothing for any of these.
REQ-015 SHALL, for any other IDLE make code with a nonzero map entry, push that ASCII value; codes FA, AA, EE, FE and unmapped codes SHALL push nothing.
REQ-016 SHALL, in BRK, move to IDLE on any byte; 12 clears shift_l, 59 clears shift_r, and nothing is pushed.
REQ-017 SHALL, in EXT, move to EXT_BRK on F0; on any other byte it SHALL move to IDLE, pushing 0x0D only if the byte is 5A.
REQ-018 SHALL, in EXT_BRK, move to IDLE on any byte without pushing.
REQ-019 SHALL use this map:
- letters 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A map to a..z;
- digits 45,16,1E,26,25,2E,36,3D,3E,46 map to '0'..'9';
- 29 -> 0x20, 5A -> 0x0D, 66 -> 0x08, 76 -> 0x1B.
REQ-020 SHALL output a letter in uppercase when (shift_l|shift_r) XOR caps is 1; digits and control codes SHALL ignore shift.
REQ-021 SHALL register each push so that key_empty=0 and key_ascii are valid in the cycle after the rx_done_tick cycle.
REQ-022 SHALL, when key_empty=0, present the oldest entry on key_ascii; rd_key pops it, and the next entry or key_empty=1 appears the following cycle.
REQ-023 SHALL ignore rd_key while key_empty=1, including a cycle with a simultaneous push.
REQ-024 SHALL, on a push into a full FIFO with rd_key=0, drop the key and set key_overflow; with rd_key=1 in the same cycle, both pop and push SHALL occur.
REQ-025 SHALL wrap pointers modulo 2**FIFO_AW and use an extra pointer bit to distinguish full from empty.
REQ-026 SHALL drive caps_led directly from the caps register.

Reset
REQ-027 SHALL, while reset=0, force: FSM = IDLE; shift_l, shift_r, caps = 0; FIFO pointers = 0; key_empty = 1; key_overflow = 0; key_ascii = 0x00; caps_led = 0.
REQ-028 SHALL, after a reset that interrupts a sequence (for example after F0 or E0), treat the next byte as received in IDLE.
REQ-029 SHALL clear key_overflow only by reset.

Structure
REQ-030 SHALL place these in shared package ps2_kb_pkg: the FSM state encoding, the constants SC_EXT=E0, SC_BRK=F0, SC_LSHIFT=12, SC_RSHIFT=59 and SC_CAPS=58, and the ASCII control constants.
REQ-031 SHALL instantiate the FIFO as sub-module key_fifo, with parameter FIFO_AW and ports clk, reset, push, din, pop, dout, empty, full.
REQ-032 SHALL implement the scan-to-ASCII map as a combinational case table inside ps2_key_decoder.

Verification
REQ-033 SHALL cover: byte 1C -> key_ascii=0x61 and key_empty=0 one cycle later; rd_key=1 -> key_empty=1.
REQ-034 SHALL cover: bytes 12,1C,F0,1C,F0,12,1C -> FIFO contents 0x41 then 0x61.
REQ-035 SHALL cover: byte 58 -> caps_led=1; then 1C -> 0x41; then 12,1C -> 0x61; then F0,58 -> caps_led stays 1.
REQ-036 SHALL cover: bytes E0,F0,5A -> nothing pushed; then E0,5A -> 0x0D; then E0,75 -> nothing pushed.
REQ-037 SHALL cover: with FIFO_AW=2, five letter makes 1C,32,21,23,24 and no reads -> key_overflow=1 and pops yield 0x61,0x62,0x63,0x64; a push on a full FIFO with rd_key=1 -> no overflow.
REQ-038 SHALL cover: byte F0, then reset pulsed low, then 1C -> 0x61 pushed and key_overflow=0.
